// File: rtl/alu_seq_pkg.sv
// -----------------------------------------------------------------------------
// alu_seq_pkg
// Shared types and constants for the sequential execute unit (alu_seq_unit).
//   alu_op_e : decoded operation carried from accept to completion
//   state_e  : control FSM states of alu_seq_unit
//   ALUOP_*  : 2-bit aluop encodings from the main decoder
//   F3_*     : funct3 encodings for R/I-type ALU instructions
// -----------------------------------------------------------------------------
package alu_seq_pkg;

  typedef enum logic [3:0] {
    OP_ADD,
    OP_SUB,
    OP_AND,
    OP_OR,
    OP_XOR,
    OP_SLL,
    OP_SRL,
    OP_SRA,
    OP_SLT,
    OP_SLTU,
    OP_MUL,
    OP_ILL
  } alu_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXEC,
    ST_SHIFT,
    ST_MUL,
    ST_DONE
  } state_e;

  localparam logic [1:0] ALUOP_MEM    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  function automatic logic is_shift(input alu_op_e op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/alu_seq_decode.sv
// -----------------------------------------------------------------------------
// alu_seq_decode
// Combinational ALU-control decode: {aluop, funct3, funct7_30, funct7_25}
// to alu_op_e. The top registers the result at accept.
// Configuration macro: ALU_MUL_EN (funct7_25 selects MUL on R-type).
// Ports:
//   aluop     in  2   00 add, 01 sub, 10 R-type, 11 I-type
//   funct3    in  3   instr[14:12]
//   funct7_30 in  1   instr[30] (SUB/SRA select)
//   funct7_25 in  1   instr[25] (MUL select, only with ALU_MUL_EN)
//   op        out     decoded operation
// -----------------------------------------------------------------------------
module alu_seq_decode
  import alu_seq_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [2:0] funct3,
  input  logic       funct7_30,
  input  logic       funct7_25,
  output alu_op_e    op
);

  logic is_rtype;
  assign is_rtype = (aluop == ALUOP_RTYPE);

  always_comb begin
    // NOTE: op gets a default before the case so every path assigns it and no latch is inferred.
    op = OP_ILL;
    case (aluop)
      ALUOP_MEM:    op = OP_ADD;
      ALUOP_BRANCH: op = OP_SUB;
      ALUOP_RTYPE, ALUOP_ITYPE: begin
        case (funct3)
          // ADDI has no SUB form, so instr[30] is immediate data there.
          F3_ADD:  op = (is_rtype && funct7_30) ? OP_SUB : OP_ADD;
          F3_SLL:  op = OP_SLL;
          F3_SLT:  op = OP_SLT;
          F3_SLTU: op = OP_SLTU;
          F3_XOR:  op = OP_XOR;
          F3_SR:   op = funct7_30 ? OP_SRA : OP_SRL;
          F3_OR:   op = OP_OR;
          F3_AND:  op = OP_AND;
        endcase
        if (is_rtype && funct7_30 && (funct3 != F3_ADD) && (funct3 != F3_SR)) begin
          op = OP_ILL;
        end
`ifdef ALU_MUL_EN
        if (is_rtype && funct7_25) begin
          op = (funct3 == F3_ADD) ? OP_MUL : OP_ILL;
        end
`endif
      end
    endcase
  end

`ifndef ALU_MUL_EN
  // Without the multiplier instr[25] carries no meaning for this unit.
  logic unused_funct7_25;
  assign unused_funct7_25 = funct7_25;
`endif

endmodule

// File: rtl/alu_seq_unit.sv
// -----------------------------------------------------------------------------
// alu_seq_unit
// Handshaked execute unit: single-cycle logic/arithmetic, one-bit-per-cycle
// shifts and (with ALU_MUL_EN defined) an XLEN-cycle shift-add multiply.
// Configuration macro: ALU_MUL_EN.
// Ports:
//   clk        in   1     rising-edge clock
//   rst        in   1     synchronous, active-high reset
//   in_valid   in   1     operation offered
//   in_ready   out  1     unit idle and able to accept
//   aluop      in   2     decoder ALU class
//   funct3     in   3     instr[14:12]
//   funct7_30  in   1     instr[30]
//   funct7_25  in   1     instr[25]
//   op_a       in   XLEN  rs1 value
//   op_b       in   XLEN  rs2 value or immediate
//   out_valid  out  1     result valid (held until out_ready)
//   out_ready  in   1     consumer accepts result
//   result     out  XLEN  registered result
//   zero       out  1     result == 0
//   illegal    out  1     undecodable operation, qualified by out_valid
// -----------------------------------------------------------------------------
module alu_seq_unit
  import alu_seq_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      aluop,
  input  logic [2:0]      funct3,
  input  logic            funct7_30,
  input  logic            funct7_25,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  localparam int SHW = $clog2(XLEN);
  // One extra bit so the multiply count can hold XLEN itself.
  localparam int CW  = SHW + 1;

  state_e          state_q, state_d;
  alu_op_e         dec_op, op_q;
  logic [XLEN-1:0] a_q, b_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] result_q;
  logic            zero_q, illegal_q;
  logic [XLEN-1:0] exec_res, shift_step, fin_res;
  logic            accept, cnt_zero, load_out;
`ifdef ALU_MUL_EN
  logic [XLEN-1:0] acc_q;
`endif

  alu_seq_decode u_decode (
    .aluop     (aluop),
    .funct3    (funct3),
    .funct7_30 (funct7_30),
    .funct7_25 (funct7_25),
    .op        (dec_op)
  );

  // in_ready stays low while rst is held so nothing is offered as accepted.
  assign in_ready  = (state_q == ST_IDLE) && !rst;
  assign out_valid = (state_q == ST_DONE);
  assign accept    = in_valid && in_ready;
  assign cnt_zero  = (cnt_q == '0);
  assign result    = result_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (is_shift(dec_op)) begin
            state_d = ST_SHIFT;
`ifdef ALU_MUL_EN
          end else if (dec_op == OP_MUL) begin
            state_d = ST_MUL;
`endif
          end else begin
            state_d = ST_EXEC;
          end
        end
      end
      ST_EXEC:  state_d = ST_DONE;
      ST_SHIFT: if (cnt_zero) state_d = ST_DONE;
`ifdef ALU_MUL_EN
      ST_MUL:   if (cnt_zero) state_d = ST_DONE;
`endif
      ST_DONE:  if (out_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    exec_res = '0;
    case (op_q)
      OP_ADD:  exec_res = a_q + b_q;
      OP_SUB:  exec_res = a_q - b_q;
      OP_AND:  exec_res = a_q & b_q;
      OP_OR:   exec_res = a_q | b_q;
      OP_XOR:  exec_res = a_q ^ b_q;
      OP_SLT:  exec_res = {{(XLEN-1){1'b0}}, $signed(a_q) < $signed(b_q)};
      OP_SLTU: exec_res = {{(XLEN-1){1'b0}}, a_q < b_q};
      default: exec_res = '0;
    endcase
  end

  always_comb begin
    case (op_q)
      OP_SLL:  shift_step = {a_q[XLEN-2:0], 1'b0};
      OP_SRA:  shift_step = {a_q[XLEN-1], a_q[XLEN-1:1]};
      default: shift_step = {1'b0, a_q[XLEN-1:1]};
    endcase
  end

  always_comb begin
    fin_res = exec_res;
    if (state_q == ST_SHIFT) fin_res = a_q;
`ifdef ALU_MUL_EN
    if (state_q == ST_MUL) fin_res = acc_q;
`endif
  end

  // Output registers load exactly once, on the edge that enters DONE.
  assign load_out = (state_q != ST_DONE) && (state_d == ST_DONE);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q   <= ST_IDLE;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load_out) begin
        result_q  <= fin_res;
        zero_q    <= (fin_res == '0);
        illegal_q <= (op_q == OP_ILL);
      end
    end
  end

  // NOTE: working registers are left unreset; they are always reloaded at accept before use.
  always_ff @(posedge clk) begin
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_q  <= dec_op;
          a_q   <= op_a;
          b_q   <= op_b;
          cnt_q <= {1'b0, op_b[SHW-1:0]};
`ifdef ALU_MUL_EN
          acc_q <= '0;
          if (dec_op == OP_MUL) cnt_q <= CW'(XLEN);
`endif
        end
      end
      ST_SHIFT: begin
        if (!cnt_zero) begin
          a_q   <= shift_step;
          cnt_q <= cnt_q - CW'(1);
        end
      end
`ifdef ALU_MUL_EN
      ST_MUL: begin
        // Shift-add: multiplicand moves left, multiplier bits are consumed LSB first.
        if (!cnt_zero) begin
          if (b_q[0]) acc_q <= acc_q + a_q;
          a_q   <= {a_q[XLEN-2:0], 1'b0};
          b_q   <= {1'b0, b_q[XLEN-1:1]};
          cnt_q <= cnt_q - CW'(1);
        end
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_seq_unit.sv
// -----------------------------------------------------------------------------
// tb_alu_seq_unit
// Directed self-checking bench for alu_seq_unit (XLEN=32). Latency is counted
// in falling edges from the one where the operation is presented (latency 0)
// to the first one where out_valid is seen high.
// Works with and without ALU_MUL_EN defined.
// -----------------------------------------------------------------------------
module tb_alu_seq_unit;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      aluop;
  logic [2:0]      funct3;
  logic            funct7_30;
  logic            funct7_25;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            illegal;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  alu_seq_unit #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .aluop     (aluop),
    .funct3    (funct3),
    .funct7_30 (funct7_30),
    .funct7_25 (funct7_25),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .illegal   (illegal)
  );

  typedef struct {
    string       name;
    logic [1:0]  aluop;
    logic [2:0]  f3;
    logic        f730;
    logic        f725;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
    logic        ill;
  } vec_t;

  vec_t alu_tbl [12] = '{
    '{"add_wrap",   2'b10, 3'b000, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 2, 1'b0},
    '{"sub_neg",    2'b10, 3'b000, 1'b1, 1'b0, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 2, 1'b0},
    '{"mem_add",    2'b00, 3'b111, 1'b1, 1'b0, 32'h0000_0010, 32'h0000_0020, 32'h0000_0030, 2, 1'b0},
    '{"branch_sub", 2'b01, 3'b101, 1'b0, 1'b0, 32'h0000_0007, 32'h0000_0007, 32'h0000_0000, 2, 1'b0},
    '{"addi_f730",  2'b11, 3'b000, 1'b1, 1'b0, 32'h0000_0003, 32'h0000_0004, 32'h0000_0007, 2, 1'b0},
    '{"and",        2'b10, 3'b111, 1'b0, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 2, 1'b0},
    '{"or",         2'b10, 3'b110, 1'b0, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 2, 1'b0},
    '{"xor",        2'b10, 3'b100, 1'b0, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 2, 1'b0},
    '{"slt",        2'b10, 3'b010, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 2, 1'b0},
    '{"sltu",       2'b10, 3'b011, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 2, 1'b0},
    '{"slti",       2'b11, 3'b010, 1'b1, 1'b0, 32'h8000_0000, 32'h0000_0000, 32'h0000_0001, 2, 1'b0},
    '{"illegal_or", 2'b10, 3'b110, 1'b1, 1'b0, 32'h1234_5678, 32'h0000_00FF, 32'h0000_0000, 2, 1'b1}
  };

  vec_t shift_tbl [7] = '{
    '{"sra31",      2'b10, 3'b101, 1'b1, 1'b0, 32'h8000_0000, 32'h0000_001F, 32'hFFFF_FFFF, 33, 1'b0},
    '{"sra0",       2'b10, 3'b101, 1'b1, 1'b0, 32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 2,  1'b0},
    '{"srl31",      2'b10, 3'b101, 1'b0, 1'b0, 32'h8000_0000, 32'h0000_001F, 32'h0000_0001, 33, 1'b0},
    '{"sll_hi_b",   2'b10, 3'b001, 1'b0, 1'b0, 32'h0000_00F1, 32'h0000_0024, 32'h0000_0F10, 6,  1'b0},
    '{"srai",       2'b11, 3'b101, 1'b1, 1'b0, 32'hF000_0000, 32'h0000_0004, 32'hFF00_0000, 6,  1'b0},
    '{"srli_hi_b",  2'b11, 3'b101, 1'b0, 1'b0, 32'hF000_0000, 32'hFFFF_FFE4, 32'h0F00_0000, 6,  1'b0},
    '{"slli1",      2'b11, 3'b001, 1'b0, 1'b0, 32'h8000_0001, 32'h0000_0001, 32'h0000_0002, 3,  1'b0}
  };

  // Present one operation, scramble the inputs right after accept, and
  // return the latency to out_valid (capped at 200 if it never arrives).
  task automatic issue(input logic [1:0] ao, input logic [2:0] f3, input logic f730,
                       input logic f725, input logic [31:0] a, input logic [31:0] b,
                       output int lat);
    int guard = 0;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    in_valid  = 1'b1;
    aluop     = ao;
    funct3    = f3;
    funct7_30 = f730;
    funct7_25 = f725;
    op_a      = a;
    op_b      = b;
    @(posedge clk);
    @(negedge clk);
    in_valid  = 1'b0;
    aluop     = ~ao;
    funct3    = ~f3;
    funct7_30 = ~f730;
    funct7_25 = ~f725;
    op_a      = ~a;
    op_b      = ~b;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    aluop     = '0;
    funct3    = '0;
    funct7_30 = 1'b0;
    funct7_25 = 1'b0;
    op_a      = '0;
    op_b      = '0;
    repeat (3) @(negedge clk);
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    else pass_cnt++;
    total_cnt++;
    if (result !== 32'h0) $display("FAIL reset_result: got %h expected 00000000", result);
    else pass_cnt++;
    total_cnt++;
    if (zero !== 1'b0) $display("FAIL reset_zero: got %b expected 0", zero);
    else pass_cnt++;
    total_cnt++;
    if (illegal !== 1'b0) $display("FAIL reset_illegal: got %b expected 0", illegal);
    else pass_cnt++;
    rst = 1'b0;
    #1;
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    else pass_cnt++;
  endtask

  task automatic test_single_cycle();
    int lat;
    foreach (alu_tbl[i]) begin
      issue(alu_tbl[i].aluop, alu_tbl[i].f3, alu_tbl[i].f730, alu_tbl[i].f725,
            alu_tbl[i].a, alu_tbl[i].b, lat);
      total_cnt++;
      if (result !== alu_tbl[i].exp)
        $display("FAIL %s result: got %h expected %h", alu_tbl[i].name, result, alu_tbl[i].exp);
      else pass_cnt++;
      total_cnt++;
      if (zero !== (alu_tbl[i].exp == 32'h0))
        $display("FAIL %s zero: got %b expected %b", alu_tbl[i].name, zero, alu_tbl[i].exp == 32'h0);
      else pass_cnt++;
      total_cnt++;
      if (illegal !== alu_tbl[i].ill)
        $display("FAIL %s illegal: got %b expected %b", alu_tbl[i].name, illegal, alu_tbl[i].ill);
      else pass_cnt++;
      total_cnt++;
      if (lat != alu_tbl[i].lat)
        $display("FAIL %s latency: got %0d expected %0d", alu_tbl[i].name, lat, alu_tbl[i].lat);
      else pass_cnt++;
      consume();
    end
  endtask

  task automatic test_shift();
    int lat;
    foreach (shift_tbl[i]) begin
      issue(shift_tbl[i].aluop, shift_tbl[i].f3, shift_tbl[i].f730, shift_tbl[i].f725,
            shift_tbl[i].a, shift_tbl[i].b, lat);
      total_cnt++;
      if (result !== shift_tbl[i].exp)
        $display("FAIL %s result: got %h expected %h", shift_tbl[i].name, result, shift_tbl[i].exp);
      else pass_cnt++;
      total_cnt++;
      if (zero !== (shift_tbl[i].exp == 32'h0))
        $display("FAIL %s zero: got %b expected %b", shift_tbl[i].name, zero, shift_tbl[i].exp == 32'h0);
      else pass_cnt++;
      total_cnt++;
      if (illegal !== 1'b0)
        $display("FAIL %s illegal: got %b expected 0", shift_tbl[i].name, illegal);
      else pass_cnt++;
      total_cnt++;
      if (lat != shift_tbl[i].lat)
        $display("FAIL %s latency: got %0d expected %0d", shift_tbl[i].name, lat, shift_tbl[i].lat);
      else pass_cnt++;
      consume();
    end
  endtask

  task automatic test_reset_mid_shift();
    bit stale = 1'b0;
    // SRL of 0xF0 by 7: accept, then reset while still counting.
    in_valid  = 1'b1;
    aluop     = 2'b10;
    funct3    = 3'b101;
    funct7_30 = 1'b0;
    funct7_25 = 1'b0;
    op_a      = 32'h0000_00F0;
    op_b      = 32'h0000_0007;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL midshift_out_valid: got %b expected 0", out_valid);
    else pass_cnt++;
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL midshift_in_ready: got %b expected 1", in_ready);
    else pass_cnt++;
    total_cnt++;
    if (result !== 32'h0) $display("FAIL midshift_result: got %h expected 00000000", result);
    else pass_cnt++;
    repeat (12) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || result !== 32'h0) stale = 1'b1;
    end
    total_cnt++;
    if (stale) $display("FAIL midshift_stale: got out_valid/result activity expected none");
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    int  lat;
    bit  unstable = 1'b0;
    bit  ready_hi = 1'b0;
    issue(2'b10, 3'b000, 1'b0, 1'b0, 32'h0000_1234, 32'h0000_0001, lat);
    // Offer the next op while the first result is still pending.
    in_valid  = 1'b1;
    aluop     = 2'b10;
    funct3    = 3'b100;
    funct7_30 = 1'b0;
    funct7_25 = 1'b0;
    op_a      = 32'h0000_00FF;
    op_b      = 32'h0000_000F;
    repeat (5) begin
      @(negedge clk);
      if (result !== 32'h0000_1235 || out_valid !== 1'b1) unstable = 1'b1;
      if (in_ready !== 1'b0) ready_hi = 1'b1;
    end
    total_cnt++;
    if (unstable) $display("FAIL bp_hold: got result %h out_valid %b expected 00001235 1", result, out_valid);
    else pass_cnt++;
    total_cnt++;
    if (ready_hi) $display("FAIL bp_in_ready: got 1 during hold expected 0");
    else pass_cnt++;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL bp_after_hs_out_valid: got %b expected 0", out_valid);
    else pass_cnt++;
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL bp_after_hs_in_ready: got %b expected 1", in_ready);
    else pass_cnt++;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    op_a     = 32'h0;
    op_b     = 32'h0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    total_cnt++;
    if (result !== 32'h0000_00F0) $display("FAIL bp_next_result: got %h expected 000000f0", result);
    else pass_cnt++;
    total_cnt++;
    if (lat != 2) $display("FAIL bp_next_latency: got %0d expected 2", lat);
    else pass_cnt++;
    consume();
  endtask

  task automatic test_mul();
    int lat;
    issue(2'b10, 3'b000, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
`ifdef ALU_MUL_EN
    total_cnt++;
    if (result !== 32'h0000_0001) $display("FAIL mul_ones_result: got %h expected 00000001", result);
    else pass_cnt++;
    total_cnt++;
    if (lat != 34) $display("FAIL mul_ones_latency: got %0d expected 34", lat);
    else pass_cnt++;
    consume();
    issue(2'b10, 3'b000, 1'b0, 1'b1, 32'h0000_0007, 32'h0000_0006, lat);
    total_cnt++;
    if (result !== 32'h0000_002A) $display("FAIL mul_small_result: got %h expected 0000002a", result);
    else pass_cnt++;
    consume();
    issue(2'b10, 3'b001, 1'b0, 1'b1, 32'h0000_0007, 32'h0000_0006, lat);
    total_cnt++;
    if (illegal !== 1'b1 || result !== 32'h0) $display("FAIL mul_f3_illegal: got %b/%h expected 1/00000000", illegal, result);
    else pass_cnt++;
`else
    total_cnt++;
    if (result !== 32'hFFFF_FFFE) $display("FAIL nomul_add_result: got %h expected fffffffe", result);
    else pass_cnt++;
    total_cnt++;
    if (lat != 2) $display("FAIL nomul_add_latency: got %0d expected 2", lat);
    else pass_cnt++;
    consume();
    issue(2'b10, 3'b111, 1'b0, 1'b1, 32'h0000_00F3, 32'h0000_003C, lat);
    total_cnt++;
    if (illegal !== 1'b0 || result !== 32'h0000_0030) $display("FAIL nomul_and: got %b/%h expected 0/00000030", illegal, result);
    else pass_cnt++;
`endif
    consume();
  endtask

  initial begin
    test_reset();
    test_single_cycle();
    test_shift();
    test_reset_mid_shift();
    test_backpressure();
    test_mul();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
